// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer with single-shot, auto-repeat and continuous enables.
//
// A raw, bouncing, active-high button level is synchronised and then qualified
// by a Moore FSM. One shared 26-bit counter times every phase: press
// qualification, hold-before-repeat, repeat spacing and release qualification.
//
// Parameters
//   DB_CNT   : cycles PB must stay stable to qualify a press or a release
//   HOLD_CNT : cycles held after the press before auto-repeat starts
//   RPT_CNT  : auto-repeat spacing control (pulses every RPT_CNT+1 cycles)
//   Each value must lie in 2..2^26-1.
//
// Ports
//   board_clk : system clock, rising edge
//   Reset     : synchronous, active-high reset
//   PB        : raw asynchronous push-button level
//   DPB       : debounced button level
//   SCEN      : one-cycle pulse per qualified press
//   MCEN      : pulse on press, then repeated pulses while held
//   CCEN      : high while held beyond HOLD_CNT
module btn_debounce_pulse #(
  parameter int unsigned DB_CNT   = 1_000_000,
  parameter int unsigned HOLD_CNT = 50_000_000,
  parameter int unsigned RPT_CNT  = 25_000_000
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);

  localparam int unsigned CntW = 26;

  localparam logic [CntW-1:0] DbLast   = CntW'(DB_CNT - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CNT - 1);
  localparam logic [CntW-1:0] RptLast  = CntW'(RPT_CNT - 1);

  typedef enum logic [2:0] {
    StIni,   // idle, button released
    StWq,    // waiting for press to qualify
    StScen,  // single-shot pulse
    StWh,    // waiting for hold time
    StMcen,  // repeat pulse
    StCcr,   // continuous, counting to next repeat
    StWfcr   // waiting for release to qualify
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync1_q, pb_s_q;

  // Two-flop synchroniser; pb_s_q is the only PB value the FSM ever sees.
  always_ff @(posedge board_clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      pb_s_q  <= 1'b0;
      state_q <= StIni;
      cnt_q   <= '0;
    end else begin
      sync1_q <= PB;
      pb_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter. Every counting state leaves or clears the counter
  // at its terminal count, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIni: begin
        if (pb_s_q) begin
          state_d = StWq;
          cnt_d   = '0;
        end
      end
      StWq: begin
        if (!pb_s_q) begin
          state_d = StIni;  // glitch rejected
        end else if (cnt_q == DbLast) begin
          state_d = StScen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScen: begin
        state_d = StWh;
        cnt_d   = '0;
      end
      StWh: begin
        if (!pb_s_q) begin
          state_d = StWfcr;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StMcen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMcen: begin
        state_d = StCcr;
        cnt_d   = '0;
      end
      StCcr: begin
        if (!pb_s_q) begin
          state_d = StWfcr;
          cnt_d   = '0;
        end else if (cnt_q == RptLast) begin
          state_d = StMcen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWfcr: begin
        if (pb_s_q) begin
          cnt_d = '0;  // release bounced; restart the release count
        end else if (cnt_q == DbLast) begin
          state_d = StIni;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIni;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    DPB  = 1'b0;
    SCEN = 1'b0;
    MCEN = 1'b0;
    CCEN = 1'b0;
    unique case (state_q)
      StIni, StWq: ;
      StScen: begin
        DPB  = 1'b1;
        SCEN = 1'b1;
        MCEN = 1'b1;
      end
      StWh, StWfcr: begin
        DPB = 1'b1;
      end
      StMcen: begin
        DPB  = 1'b1;
        MCEN = 1'b1;
        CCEN = 1'b1;
      end
      StCcr: begin
        DPB  = 1'b1;
        CCEN = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
